if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Stage-1 front end of the 5-stage MIPS pipeline: owns the PC register, next-PC selection, instruction-memory addressing and the IF/ID pipeline register.
- Feeds the ID stage (decode/register file) with instruction and PC+4.
- Consumes the load-use stall from the hazard logic and the branch/jump redirect resolved in MEM/WB.
- Squashes wrong-path instructions by inserting bubbles.

Parameters:
- NBits, 32, datapath/PC width.
- MEMORY_DEPTH, 512, instruction memory depth in words; bounds the legal fetch range.
- PC_RESET, 32'h0040_0000, PC value after reset; text-segment base.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect_valid  in  1  taken branch/jump/jr from MEM/WB this cycle.
- redirect_target  in  NBits  new PC for redirect.
- imem_addr  out  NBits  byte address to instruction ROM; equals current PC.
- imem_data  in  NBits  combinational ROM read data for imem_addr.
- id_instruction  out  NBits  IF/ID registered instruction.
- id_pc_4  out  NBits  IF/ID registered PC+4.
- id_valid  out  1  IF/ID holds a real instruction; 0 = bubble (id_instruction forced to 0, NOP).
- flush_downstream  out  1  one-cycle pulse, registered, asking ID/EX and EX/MEM to bubble.
- halted  out  1  fetch stopped, PC out of range.
- misalign_err  out  1  sticky; a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (reset=0, async) forces these values immediately:
  - PC=PC_RESET; id_instruction=0; id_pc_4=0; id_valid=0.
  - flush_downstream=0; halted=0; misalign_err=0; state=BOOT.
- States:
  - BOOT: one cycle after reset deasserts. PC is not advanced and IF/ID loads a bubble. Go to RUN.
  - RUN: normal fetch.
  - HALT: PC word index (PC-PC_RESET)>>2 >= MEMORY_DEPTH, or PC < PC_RESET. Entered on the edge after an out-of-range PC is observed. IF/ID loads bubbles, halted=1. Exits to RUN only on a redirect with an in-range target.
- RUN priority per edge, highest first:
  1. redirect_valid=1:
     - PC <= {redirect_target[NBits-1:2],2'b00}.
     - IF/ID <= bubble.
     - flush_downstream <= 1 for exactly one cycle.
     - If target[1:0]!=0, misalign_err <= 1 (sticky until reset).
     - Redirect overrides a simultaneous stall.
  2. stall=1: PC, id_instruction, id_pc_4 and id_valid all hold their values.
  3. Otherwise: PC <= PC+4 (mod 2^NBits); id_instruction <= imem_data; id_pc_4 <= PC+4; id_valid <= 1.
- Fetch latency: the instruction at PC appears on id_instruction one edge later.
- After a redirect, the first target-path instruction is visible on ID two edges after redirect_valid is sampled: one edge loads the PC, the next loads IF/ID.
- flush_downstream is 0 whenever no redirect was sampled on the previous edge.
- imem_addr = PC combinationally; no address wrap. Wrap of PC+4 past 2^NBits yields an out-of-range PC, which leads to HALT.
- A stall held for any length freezes all state; the state machine does not change on stall.

Optional Feature:
- Macro: IF_PERF_COUNTERS_EN.
- Defined: adds three NBits-wide saturating outputs, all reset to 0 and counting only in RUN:
  - perf_fetched: increments on each edge that loads a valid instruction.
  - perf_stalled: increments on each stall-hold edge.
  - perf_flushed: increments on each redirect.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pipeline_pkg:
  - fetch state encoding (BOOT, RUN, HALT).
  - NOP_INSTRUCTION = 32'h0000_0000.
  - PC_RESET default.
  - INSTR_BYTES = 4.
- One sub-module, if_id_stage_register: IF/ID storage with stall-hold and flush-to-bubble inputs. It is reusable as the pattern for the other pipeline registers.

Test Plan:
- Reset then free-run with ROM word0=32'h2008_0005, word1=32'h2009_0003 → BOOT cycle has id_valid=0. Next edges give id_instruction=32'h2008_0005, id_pc_4=32'h0040_0004, then 32'h2009_0003 with id_pc_4=32'h0040_0008.
- stall high for 3 cycles at PC=32'h0040_0008 → imem_addr, id_instruction and id_pc_4 unchanged for 3 cycles; fetch resumes at 32'h0040_000C.
- redirect_valid=1 and stall=1 together, target=32'h0040_0020 → redirect wins: PC=32'h0040_0020, id_valid=0, flush_downstream high one cycle. The next edge gives id_pc_4=32'h0040_0024.
- Redirect target=32'h0040_0013 → PC=32'h0040_0010, misalign_err=1. It stays 1 across later cycles until reset.
- Run PC to 32'h0040_0800 with MEMORY_DEPTH=512 → halted=1 and id_valid=0 from the next edge. A redirect to 32'h0040_0000 returns the block to RUN.
- Assert reset low asynchronously mid-stream with id_valid=1 → all outputs reach reset values without a clock edge, and PC=32'h0040_0000.

Source files
------------

// File: rtl/mips_pipeline_pkg.sv
// Shared MIPS pipeline definitions: fetch states and fetch constants.
package mips_pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
  localparam int unsigned INSTR_BYTES      = 4;

endpackage

// File: rtl/if_id_stage_register.sv
// IF/ID pipeline register with stall-hold and flush-to-bubble.
module if_id_stage_register
  import mips_pipeline_pkg::*;
#(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [NBits-1:0] next_instruction,
  input  logic [NBits-1:0] next_pc_4,
  output logic [NBits-1:0] instruction,
  output logic [NBits-1:0] pc_4,
  output logic             valid
);

  // Flush beats stall so a squash is never lost behind a hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= NBits'(NOP_INSTRUCTION);
      pc_4        <= '0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NBits'(NOP_INSTRUCTION);
      pc_4        <= '0;
      valid       <= 1'b0;
    end else if (!stall) begin
      instruction <= next_instruction;
      pc_4        <= next_pc_4;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC, next-PC select, IF/ID register.
// Optional perf counters under IF_PERF_COUNTERS_EN.
module if_fetch_unit
  import mips_pipeline_pkg::*;
#(
  parameter int               NBits        = 32,
  parameter int               MEMORY_DEPTH = 512,
  parameter logic [NBits-1:0] PC_RESET     = NBits'(PC_RESET_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [NBits-1:0] redirect_target,
  output logic [NBits-1:0] imem_addr,
  input  logic [NBits-1:0] imem_data,
  output logic [NBits-1:0] id_instruction,
  output logic [NBits-1:0] id_pc_4,
  output logic             id_valid,
  output logic             flush_downstream,
  output logic             halted,
  output logic             misalign_err
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [NBits-1:0] perf_fetched,
  output logic [NBits-1:0] perf_stalled,
  output logic [NBits-1:0] perf_flushed
`endif
);

  fetch_state_t     state, state_next;
  logic [NBits-1:0] pc, pc_next, pc_plus4;
  logic [NBits-1:0] target_aligned;
  logic             pc_in_range;
  logic             target_in_range;
  logic             take_redirect;
  logic             fetch;
  logic             hold;
  logic             bubble;
  logic             flush_next;
  logic             misalign_next;

  function automatic logic in_range(input logic [NBits-1:0] a);
    logic [NBits-1:0] off;
    off = a - PC_RESET;
    return (a >= PC_RESET) &&
           ((off >> 2) < NBits'(MEMORY_DEPTH));
  endfunction

  assign pc_plus4        = pc + NBits'(INSTR_BYTES);
  assign target_aligned  = {redirect_target[NBits-1:2], 2'b00};
  assign pc_in_range     = in_range(pc);
  assign target_in_range = in_range(target_aligned);
  assign imem_addr       = pc;
  assign halted          = (state == HALT);

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    flush_next    = 1'b0;
    misalign_next = misalign_err;
    take_redirect = 1'b0;
    fetch         = 1'b0;
    hold          = 1'b0;
    bubble        = 1'b0;
    unique case (state)
      BOOT: begin
        if (stall) begin
          hold = 1'b1;
        end else begin
          bubble     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          take_redirect = 1'b1;
        end else if (stall) begin
          hold = 1'b1;
        end else if (!pc_in_range) begin
          bubble     = 1'b1;
          state_next = HALT;
        end else begin
          fetch   = 1'b1;
          pc_next = pc_plus4;
        end
      end
      HALT: begin
        // Only an in-range target can revive fetch.
        if (redirect_valid && target_in_range) begin
          take_redirect = 1'b1;
          state_next    = RUN;
        end else if (stall) begin
          hold = 1'b1;
        end else begin
          bubble = 1'b1;
        end
      end
      default: begin
        state_next = BOOT;
        bubble     = 1'b1;
      end
    endcase
    if (take_redirect) begin
      pc_next    = target_aligned;
      bubble     = 1'b1;
      flush_next = 1'b1;
      if (|redirect_target[1:0]) misalign_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= BOOT;
      pc               <= PC_RESET;
      flush_downstream <= 1'b0;
      misalign_err     <= 1'b0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      flush_downstream <= flush_next;
      misalign_err     <= misalign_next;
    end
  end

  if_id_stage_register #(
    .NBits(NBits)
  ) u_if_id (
    .clk             (clk),
    .rst_n           (reset),
    .stall           (hold),
    .flush           (bubble),
    .next_instruction(imem_data),
    .next_pc_4       (pc_plus4),
    .instruction     (id_instruction),
    .pc_4            (id_pc_4),
    .valid           (id_valid)
  );

`ifdef IF_PERF_COUNTERS_EN
  logic run_st;
  assign run_st = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stalled <= '0;
      perf_flushed <= '0;
    end else if (run_st) begin
      if (fetch && !(&perf_fetched))
        perf_fetched <= perf_fetched + 1'b1;
      if (hold && !(&perf_stalled))
        perf_stalled <= perf_stalled + 1'b1;
      if (take_redirect && !(&perf_flushed))
        perf_flushed <= perf_flushed + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed literals plus
// randomized stimulus against a behavioural fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] PC_RESET = 32'h0040_0000;
  localparam int          MEMORY_DEPTH = 512;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_4;
  logic        id_valid;
  logic        flush_downstream;
  logic        halted;
  logic        misalign_err;

  logic [31:0] rom [MEMORY_DEPTH];

  int tests = 0;
  int fails = 0;
  bit en_cmp = 1'b0;

  logic [31:0] m_pc, m_instr, m_pc4, m_tgt;
  logic        m_valid, m_flush, m_mis;
  int          m_mode;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .NBits(32),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .PC_RESET(PC_RESET)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .id_instruction  (id_instruction),
    .id_pc_4         (id_pc_4),
    .id_valid        (id_valid),
    .flush_downstream(flush_downstream),
    .halted          (halted),
    .misalign_err    (misalign_err)
  );

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= PC_RESET) && (a < PC_RESET + 32'(4 * MEMORY_DEPTH));
  endfunction

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    int i;
    if (!in_rng(a)) return 32'hDEAD_BEEF;
    i = int'((a - PC_RESET) / 4);
    return rom[i];
  endfunction

  assign imem_data = rom_at(imem_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural fetch model, advanced on the same edges as the DUT.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = PC_RESET; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_flush = 0; m_mis = 0; m_mode = M_BOOT;
    end else begin
      m_flush = 0;
      m_tgt = redirect_target & 32'hFFFF_FFFC;
      if (m_mode == M_BOOT) begin
        if (!stall) begin
          m_instr = 0; m_pc4 = 0; m_valid = 0; m_mode = M_RUN;
        end
      end else if (redirect_valid &&
                   (m_mode == M_RUN || in_rng(m_tgt))) begin
        m_pc = m_tgt; m_instr = 0; m_pc4 = 0; m_valid = 0;
        m_flush = 1; m_mode = M_RUN;
        if (redirect_target % 4 != 0) m_mis = 1;
      end else if (stall) begin
      end else if (m_mode == M_HALT || !in_rng(m_pc)) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0; m_mode = M_HALT;
      end else begin
        m_instr = rom[(m_pc - PC_RESET) / 4];
        m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("id_instruction", id_instruction, m_instr);
      chk("id_pc_4", id_pc_4, m_pc4);
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("flush_downstream", 32'(flush_downstream), 32'(m_flush));
      chk("halted", 32'(halted), 32'(m_mode == M_HALT));
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_target();
    int c;
    c = int'($urandom_range(0, 9));
    case (c)
      0: return PC_RESET - 32'(4 * $urandom_range(1, 4));
      1: return 32'h0040_0800 + 32'($urandom_range(0, 15));
      2: return 32'hFFFF_FFFC;
      default: return PC_RESET + 32'($urandom_range(0, 2047));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < MEMORY_DEPTH; i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0003;
    stall = 0; redirect_valid = 0; redirect_target = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 en_cmp = 1'b1;
    tick(); tick();
    chk("rst_pc", imem_addr, 32'h0040_0000);
    chk("rst_valid", 32'(id_valid), 32'd0);
    reset = 1'b1;
    tick();
    chk("boot_valid", 32'(id_valid), 32'd0);
    chk("boot_pc", imem_addr, 32'h0040_0000);
    tick();
    chk("f0_instr", id_instruction, 32'h2008_0005);
    chk("f0_pc4", id_pc_4, 32'h0040_0004);
    tick();
    chk("f1_instr", id_instruction, 32'h2009_0003);
    chk("f1_pc4", id_pc_4, 32'h0040_0008);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", imem_addr, 32'h0040_0008);
      chk("stall_instr", id_instruction, 32'h2009_0003);
      chk("stall_pc4", id_pc_4, 32'h0040_0008);
    end
    stall = 0;
    tick();
    chk("resume_pc", imem_addr, 32'h0040_000C);
    chk("resume_pc4", id_pc_4, 32'h0040_000C);
    stall = 1; redirect_valid = 1; redirect_target = 32'h0040_0020;
    tick();
    chk("redir_pc", imem_addr, 32'h0040_0020);
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_flush", 32'(flush_downstream), 32'd1);
    stall = 0; redirect_valid = 0;
    tick();
    chk("redir_pc4", id_pc_4, 32'h0040_0024);
    chk("redir_flush_off", 32'(flush_downstream), 32'd0);
    redirect_valid = 1; redirect_target = 32'h0040_0013;
    tick();
    chk("mis_pc", imem_addr, 32'h0040_0010);
    chk("mis_err", 32'(misalign_err), 32'd1);
    redirect_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mis_sticky", 32'(misalign_err), 32'd1);
    end
    redirect_valid = 1; redirect_target = 32'h0040_07F8;
    tick();
    redirect_valid = 0;
    tick(); tick();
    chk("end_pc", imem_addr, 32'h0040_0800);
    chk("end_not_halted", 32'(halted), 32'd0);
    tick();
    chk("halt", 32'(halted), 32'd1);
    chk("halt_valid", 32'(id_valid), 32'd0);
    redirect_valid = 1; redirect_target = 32'h0000_0000;
    tick();
    chk("halt_bad_redir", 32'(halted), 32'd1);
    redirect_target = 32'h0040_0000;
    tick();
    chk("halt_exit", 32'(halted), 32'd0);
    chk("halt_exit_pc", imem_addr, 32'h0040_0000);
    redirect_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_target = rand_target();
      tick();
    end
    stall = 0; redirect_valid = 1; redirect_target = 32'h0040_0000;
    tick();
    redirect_valid = 0;
    tick(); tick();
    chk("pre_rst_valid", 32'(id_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", imem_addr, 32'h0040_0000);
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_instr", id_instruction, 32'd0);
    chk("arst_pc4", id_pc_4, 32'd0);
    chk("arst_mis", 32'(misalign_err), 32'd0);
    chk("arst_halt", 32'(halted), 32'd0);
    chk("arst_flush", 32'(flush_downstream), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_instr", id_instruction, 32'h2009_0003);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
